// File: rtl/agc_pkg.sv
// Shared types and defaults for the windowed AGC block.
// Optional build macro used by agc_window_ctrl: AGC_FAST_OVERLOAD_EN.
package agc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        SAMPLING = 2'd2,
        EVAL     = 2'd3
    } agc_state_t;

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2
    } agc_dec_t;

    // Defaults for the 4-level, 12-bit front end; level 0 in the low slice.
    localparam int          DEF_LEVELS    = 4;
    localparam int          DEF_DATA_W    = 12;
    localparam logic [47:0] DEF_THR_LOWER = {12'd1798, 12'd1792, 12'd1792, 12'd1792};
    localparam logic [47:0] DEF_THR_UPPER = {12'd3884, 12'd3723, 12'd3884, 12'd3686};

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/agc_peak_tracker.sv
// Min/max accumulator over one measurement window with a sticky overload flag.
// The first valid sample after clear loads both extremes.
module agc_peak_tracker #(
    parameter int DATA_W        = 12,
    parameter int OVERLOAD_CODE = 3944
) (
    input  logic              adc_clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] max_val,
    output logic [DATA_W-1:0] min_val,
    output logic              overload
);

    localparam logic [DATA_W-1:0] OVF_CODE = DATA_W'(OVERLOAD_CODE);

    logic loaded;

    always_ff @(posedge adc_clk) begin
        if (!rst_n || clear) begin
            max_val  <= '0;
            min_val  <= '0;
            overload <= 1'b0;
            loaded   <= 1'b0;
        end else if (valid) begin
            loaded <= 1'b1;
            if (!loaded || data > max_val) max_val <= data;
            if (!loaded || data < min_val) min_val <= data;
            if (data > OVF_CODE) overload <= 1'b1;
        end
    end

endmodule

// File: rtl/agc_window_ctrl.sv
// Windowed AGC: measures peak-to-peak per window and steps an N-level gain index.
// Build macro AGC_FAST_OVERLOAD_EN aborts a window on the first overload sample.
module agc_window_ctrl
    import agc_pkg::*;
#(
    parameter int DATA_W        = 12,
    parameter int GAIN_LEVELS   = 4,
    parameter int WINDOW_LEN    = 512,
    parameter int STABLE_CYCLES = 5,
    parameter int SETTLE_CYCLES = 16,
    parameter int OVERLOAD_CODE = 3944
) (
    input  logic                           adc_clk,
    input  logic                           rst_n,
    input  logic [DATA_W-1:0]              adc_data,
    input  logic                           adc_valid,
    input  logic                           enable,
    input  logic [GAIN_LEVELS*DATA_W-1:0]  thr_lower,
    input  logic [GAIN_LEVELS*DATA_W-1:0]  thr_upper,
    output logic [$clog2(GAIN_LEVELS)-1:0] gain_ctrl,
    output logic                           gain_update,
    output logic [DATA_W-1:0]              peak_value,
    output logic                           overload,
    output logic                           stable,
    output agc_state_t                     state_dbg
);

    localparam int GAIN_W = $clog2(GAIN_LEVELS);
    localparam int WIN_W  = cnt_w(WINDOW_LEN);
    localparam int SET_W  = cnt_w(SETTLE_CYCLES);
    localparam int STB_W  = cnt_w(STABLE_CYCLES + 1);

    localparam logic [GAIN_W-1:0] GAIN_MAX = GAIN_W'(GAIN_LEVELS - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW_LEN - 1);
    localparam logic [SET_W-1:0]  SET_LAST = SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [STB_W-1:0]  STB_MAX  = STB_W'(STABLE_CYCLES);
    localparam logic [DATA_W-1:0] OVF_CODE = DATA_W'(OVERLOAD_CODE);

    agc_state_t        state, state_next;
    agc_dec_t          dec;
    logic              in_band;
    logic [WIN_W-1:0]  win_cnt;
    logic [SET_W-1:0]  settle_cnt;
    logic [STB_W-1:0]  stable_cnt;
    logic              trk_clear, trk_valid, trk_ovf;
    logic [DATA_W-1:0] trk_max, trk_min, peak, thr_lo, thr_hi;
    logic              sample_ovf;

    agc_peak_tracker #(
        .DATA_W        (DATA_W),
        .OVERLOAD_CODE (OVERLOAD_CODE)
    ) u_tracker (
        .adc_clk  (adc_clk),
        .rst_n    (rst_n),
        .clear    (trk_clear),
        .valid    (trk_valid),
        .data     (adc_data),
        .max_val  (trk_max),
        .min_val  (trk_min),
        .overload (trk_ovf)
    );

    assign peak       = trk_max - trk_min;
    assign thr_lo     = thr_lower[int'(gain_ctrl) * DATA_W +: DATA_W];
    assign thr_hi     = thr_upper[int'(gain_ctrl) * DATA_W +: DATA_W];
    assign sample_ovf = adc_valid && (adc_data > OVF_CODE);
    assign stable     = (stable_cnt == STB_MAX);
    assign state_dbg  = state;

    always_ff @(posedge adc_clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        dec        = HOLD;
        in_band    = 1'b0;
        trk_clear  = (state != SAMPLING);
        trk_valid  = adc_valid && (state == SAMPLING);

        // First matching rule decides; a rule pinned at a gain limit still wins.
        if (trk_ovf) begin
            if (gain_ctrl != '0) dec = STEP_DOWN;
        end else if (peak > thr_hi) begin
            if (gain_ctrl != '0) dec = STEP_DOWN;
        end else if (peak < thr_lo) begin
            if (gain_ctrl != GAIN_MAX) dec = STEP_UP;
        end else begin
            in_band = 1'b1;
        end

        case (state)
            IDLE:     if (enable) state_next = SETTLE;
            SETTLE:   if (SETTLE_CYCLES == 0 || (adc_valid && settle_cnt == SET_LAST))
                          state_next = SAMPLING;
            SAMPLING: begin
                if (adc_valid && win_cnt == WIN_LAST) state_next = EVAL;
`ifdef AGC_FAST_OVERLOAD_EN
                if (sample_ovf) state_next = EVAL;
`endif
            end
            EVAL:     state_next = (dec != HOLD) ? SETTLE : SAMPLING;
            default:  state_next = IDLE;
        endcase

        if (!enable) state_next = IDLE;
    end

    always_ff @(posedge adc_clk) begin
        if (!rst_n) begin
            gain_ctrl   <= '0;
            gain_update <= 1'b0;
            peak_value  <= '0;
            overload    <= 1'b0;
            stable_cnt  <= '0;
            win_cnt     <= '0;
            settle_cnt  <= '0;
        end else begin
            gain_update <= 1'b0;

            if (state != SETTLE || state_next != SETTLE) settle_cnt <= '0;
            else if (adc_valid)                          settle_cnt <= settle_cnt + 1'b1;

            if (state != SAMPLING || state_next != SAMPLING) win_cnt <= '0;
            else if (adc_valid)                              win_cnt <= win_cnt + 1'b1;

            if (state == EVAL && enable) begin
                peak_value  <= peak;
                overload    <= trk_ovf;
                gain_update <= (dec != HOLD);
                if (dec == STEP_UP)   gain_ctrl <= gain_ctrl + 1'b1;
                if (dec == STEP_DOWN) gain_ctrl <= gain_ctrl - 1'b1;
                if (!in_band)                  stable_cnt <= '0;
                else if (stable_cnt != STB_MAX) stable_cnt <= stable_cnt + 1'b1;
            end else if (!enable) begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/agc_window_ctrl.md
# agc_window_ctrl

Parametrised windowed automatic gain controller and successor to the fixed 4-level, 12-bit AGC. It observes the ADC stream and measures peak-to-peak amplitude over a window of valid samples. It then steps an N-level programmable-gain index toward a runtime-programmable target band per level, and blanks samples while the analog front end settles after each change. It sits between the ADC capture interface and the PGA/relay control pins, with thresholds supplied by the register block.

## Interface
Parameters:
- DATA_W, 12: ADC sample width, unsigned codes.
- GAIN_LEVELS, 4: number of gain levels (≥2). Index 0 is the lowest gain; GAIN_W = $clog2(GAIN_LEVELS).
- WINDOW_LEN, 512: valid samples per measurement window (≥2).
- STABLE_CYCLES, 5: consecutive in-band windows required to assert stable.
- SETTLE_CYCLES, 16: valid samples discarded after every gain change and after enable.
- OVERLOAD_CODE, 3944: a sample strictly greater than this value is an overload.

Ports:
- adc_clk, in, 1: single clock for the whole block.
- rst_n, in, 1: reset, synchronous and active-low.
- adc_data, in, DATA_W: sample; qualified by adc_valid.
- adc_valid, in, 1: sample strobe; may have gaps.
- enable, in, 1: run control.
- thr_lower, in, GAIN_LEVELS*DATA_W: packed per-level lower bounds; slice g is bits [g*DATA_W +: DATA_W].
- thr_upper, in, GAIN_LEVELS*DATA_W: packed per-level upper bounds, same slicing as thr_lower.
- gain_ctrl, out, GAIN_W: current gain index.
- gain_update, out, 1: one-cycle pulse when gain_ctrl changes.
- peak_value, out, DATA_W: max−min of the last evaluated window.
- overload, out, 1: the last evaluated window contained an overload.
- stable, out, 1: stable counter equals STABLE_CYCLES.

## Operation
- States: IDLE, SETTLE, SAMPLING, EVAL.
- IDLE: entered from reset or whenever enable is low; the transition happens on the next edge from any state. Gain is held, the window is discarded and the stable counter is cleared. enable high → SETTLE.
- SETTLE: count SETTLE_CYCLES valid samples, ignoring their data, then go to SAMPLING.
- SAMPLING:
  - The first valid sample loads both max and min; later valid samples update them.
  - Any valid sample > OVERLOAD_CODE sets the sticky window overload flag.
  - After the WINDOW_LEN-th valid sample, go to EVAL.
- EVAL (one cycle): peak = max − min (DATA_W unsigned; max ≥ min by construction). The decision uses priority order:
  1. Overload flag: step down if gain > 0.
  2. peak > thr_upper[g]: step down if gain > 0.
  3. peak < thr_lower[g]: step up if gain < GAIN_LEVELS−1.
  4. Otherwise hold.
- Stable counter:
  - An in-band hold increments it, saturating at STABLE_CYCLES.
  - Any step, or any out-of-band result pinned at a limit (gain unchanged, no gain_update), clears it.
- After EVAL: if the gain changed → SETTLE, else → SAMPLING with the window cleared.
- thr_lower and thr_upper are read combinationally in EVAL; software changes them only while enable is low. Inverted thresholds (lower > upper) are not checked, and the priority order above governs.

## Timing
- Reset values: gain_ctrl 0, gain_update 0, peak_value 0, overload 0, stable 0, state IDLE, all counters 0.
- A reset mid-window takes effect on the next adc_clk edge; no partial update is emitted.
- At the EVAL edge, gain_ctrl, gain_update, peak_value, overload and stable all update together, visible one cycle after EVAL. No stale-target lag: the decided gain is applied directly.
- Window latency: SETTLE_CYCLES + WINDOW_LEN valid samples + 1 cycle from enable to the first update.
- adc_valid low freezes all counters and trackers; only valid samples count.

## Configuration
- AGC_FAST_OVERLOAD_EN defined:
  - An overload sample in SAMPLING aborts the window immediately; the next cycle behaves as EVAL with overload forced.
  - gain_ctrl decrements within 2 cycles of the offending sample, then SETTLE.
  - At gain 0 the window aborts, overload is reported and the block returns to SAMPLING.
- AGC_FAST_OVERLOAD_EN undefined: overload is acted on only at the normal EVAL.

## Structure
- Package agc_pkg holds:
  - state enum agc_state_t;
  - decision enum agc_dec_t {HOLD, STEP_UP, STEP_DOWN};
  - default threshold localparams for the 4-level front end (lower 1792/1792/1792/1798, upper 3686/3884/3723/3884).
- Sub-module agc_peak_tracker: min/max accumulator with clear, valid and first-sample load; outputs max, min and an overload flag.

## Test plan
1. rst_n low 3 cycles while enable and valid toggle → all outputs 0. Then enable, square wave 1000/3000 (peak 2000), all thresholds 1792/3686 → no gain_update, stable rises one cycle after the 5th EVAL, peak_value = 2000.
2. Square wave 1500/2000 (peak 500) → gain_update pulses on 3 consecutive windows, gain 0→1→2→3. Gain then stays 3 with no further pulses and stable = 0.
3. At gain 2, square wave 100/3900 (peak 3800) → gain 1 after the window, SETTLE observed (16 valid samples ignored).
4. At gain 2, single sample 4000 at window sample 100:
   - with AGC_FAST_OVERLOAD_EN: gain 1 within 2 cycles;
   - without it: gain 1 only at window end, overload = 1.
5. Drop enable at sample 300 → IDLE next cycle, no gain_update, stable 0. Re-enable → full SETTLE + window.
6. adc_valid at 50% duty, in-band signal → EVAL every 1025 cycles after settle; assert rst_n low mid-window → reset values on the next edge.
